axi_default_slave: RTL
======================

Name: axi_default_slave

Overview:
- Default (decode-error) slave on the AXI crossbar. It terminates every read and write transaction that the arbiters route to no real slave (ROM/IM/DM/Sctrl/WDT/DRAM miss, i.e. the `Mx_NO_R` / `Mx_NO_W` routes).
- It completes full AXI handshakes with DECERR responses, so an unmapped access never hangs the bus.
- It is the responder end of the read/write address channels that the arbiters drive.

Parameters:
- IDW, 8, slave-side ID width (master ID plus master tag).
- DW, 32, data width.
- LW, 4, burst length field width (beats = LEN+1, max 16).

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  synchronous reset, active-low.
- ARID  in  IDW  read address ID.
- ARLEN  in  LW  read burst length.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RID  out  IDW  read data ID.
- RDATA  out  DW  read data, always 0.
- RRESP  out  2  read response.
- RLAST  out  1  last read beat.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- AWID  in  IDW  write address ID.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WLAST  in  1  last write beat.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BID  out  IDW  write response ID.
- BRESP  out  2  write response.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.

ARADDR/AWADDR/ARSIZE/ARBURST/WDATA/WSTRB are not ports; the address is already decoded upstream and the data is discarded.

Behaviour:
- Reset: ARESETn synchronous, active-low; clock ACLK. On reset, both FSMs go to IDLE and registers clear:
  - rid, bid, beat counter and arlen latch are cleared to 0.
  - Outputs in reset: ARREADY=1, AWREADY=1 (Moore outputs of IDLE; legal because masters hold VALID low in reset); RVALID=0, RLAST=0, RID=0, RDATA=0, RRESP=2'b11, WREADY=0, BVALID=0, BID=0, BRESP=2'b11.
- Read and write FSMs are fully independent; concurrent read and write transactions are allowed.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. On ARVALID&ARREADY at edge k, latch ARID into rid and ARLEN into rlen, clear cnt, then go to R_DATA.
  - R_DATA: ARREADY=0, RVALID=1 from cycle k+1 (one-cycle latency). RID=rid, RDATA=0, RRESP=DECERR (2'b11), RLAST=(cnt==rlen).
  - Each RVALID&RREADY increments cnt. On the beat with RLAST=1, return to R_IDLE; ARREADY=1 in the following cycle.
  - RREADY low: hold all R outputs stable (RVALID must not drop).
  - Exactly ARLEN+1 beats are sent. ARLEN=0 gives a single beat with RLAST=1. ARLEN=4'hF gives 16 beats; cnt is LW bits and never wraps before RLAST.
  - Back-to-back: ARVALID presented while in R_DATA is not accepted until R_IDLE.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: AWREADY=1, WREADY=0. On AWVALID&AWREADY, latch AWID into bid and go to W_DATA.
  - W_DATA: WREADY=1. Each WVALID&WREADY beat is discarded. The beat with WLAST=1 moves the FSM to W_RESP. Termination depends on WLAST only; AWLEN is not checked.
  - W_RESP: BVALID=1 the cycle after the WLAST handshake, with BID=bid and BRESP=DECERR. On BVALID&BREADY, go to W_IDLE.
  - W data arriving before the AW handshake is not accepted (WREADY=0 in W_IDLE).
- Reset mid-burst: both FSMs abort to IDLE immediately; no RLAST or B is issued for the aborted transaction.
- All outputs are driven from registers or state decode; there is no combinational path from any input to any output.

Decomposition:
- Shared AXI package (alongside AXI_def.svh): RESP_OKAY=2'b00, RESP_DECERR=2'b11; typedef enums for rd_state_t {R_IDLE,R_DATA} and wr_state_t {W_IDLE,W_DATA,W_RESP}; AXI_IDS_BITS/AXI_LEN_BITS defaults.
- Single module; no sub-module. The read and write FSMs are two always_ff blocks plus output decode.

Test Plan:
- Single read: ARID=8'h12, ARLEN=0, RREADY=1 -> ARREADY falls the cycle after the handshake; one beat with RID=8'h12, RDATA=0, RRESP=2'b11, RLAST=1; ARREADY=1 again the following cycle.
- Burst read with backpressure: ARLEN=3, RREADY toggling 1,0,1,0... -> exactly 4 RVALID&RREADY beats; RLAST only on the 4th; outputs stable while RREADY=0.
- Max burst: ARLEN=4'hF -> 16 beats, RLAST on beat 16 only, FSM back to R_IDLE.
- Write: AWID=8'h25, 2 W beats with WLAST on the 2nd, BREADY held 0 for 3 cycles -> WREADY=0 before AW; BVALID rises the cycle after WLAST, held with BID=8'h25, BRESP=2'b11 until BREADY=1, then AWREADY=1.
- Concurrency: an AR (ARLEN=1) and an AW in the same cycle -> both accepted in that cycle; R and B complete independently with correct IDs.
- Reset mid-burst: ARLEN=7, ARESETn low after beat 2 -> next cycle RVALID=0, ARREADY=1, and a new ARLEN=0 read completes normally.

Source files
------------

// File: rtl/axi_default_slave_pkg.sv
// Shared AXI definitions for the default (decode-error) slave: response
// codes, field-width defaults and the read/write FSM state types.
package axi_default_slave_pkg;

  localparam int AXI_IDS_BITS  = 8;
  localparam int AXI_DATA_BITS = 32;
  localparam int AXI_LEN_BITS  = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } wr_state_t;

endpackage

// File: rtl/axi_default_slave_if.sv
// AXI subset seen by the default slave: AR/R and AW/W/B handshakes, IDs,
// burst length and WLAST. Address, size, burst type and write data are not
// carried because the route is already decoded and the data is discarded.
interface axi_default_slave_if
  import axi_default_slave_pkg::*;
#(
  parameter int IDW = AXI_IDS_BITS,
  parameter int DW  = AXI_DATA_BITS,
  parameter int LW  = AXI_LEN_BITS
) ();

  logic [IDW-1:0] ARID;
  logic [LW-1:0]  ARLEN;
  logic           ARVALID;
  logic           ARREADY;

  logic [IDW-1:0] RID;
  logic [DW-1:0]  RDATA;
  logic [1:0]     RRESP;
  logic           RLAST;
  logic           RVALID;
  logic           RREADY;

  logic [IDW-1:0] AWID;
  logic           AWVALID;
  logic           AWREADY;

  logic           WLAST;
  logic           WVALID;
  logic           WREADY;

  logic [IDW-1:0] BID;
  logic [1:0]     BRESP;
  logic           BVALID;
  logic           BREADY;

  modport slave (
    input  ARID, ARLEN, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY,
    input  AWID, AWVALID,
    output AWREADY,
    input  WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY
  );

  modport master (
    output ARID, ARLEN, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY,
    output AWID, AWVALID,
    input  AWREADY,
    output WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY
  );

endinterface

// File: rtl/axi_default_slave.sv
// Default slave for the AXI crossbar. Terminates every unmapped read and
// write with full handshakes and DECERR responses so the bus never hangs.
// Read and write sides are independent FSMs; all outputs come from
// registers or state decode, with no input-to-output combinational path.
module axi_default_slave
  import axi_default_slave_pkg::*;
#(
  parameter int IDW = AXI_IDS_BITS,
  parameter int DW  = AXI_DATA_BITS,
  parameter int LW  = AXI_LEN_BITS
) (
  input logic               ACLK,
  input logic               ARESETn,
  axi_default_slave_if.slave s
);

  rd_state_t      r_rd_state;
  logic [IDW-1:0] r_rid;
  logic [LW-1:0]  r_rlen;
  logic [LW-1:0]  r_cnt;

  wr_state_t      r_wr_state;
  logic [IDW-1:0] r_bid;

  logic w_rlast;
  assign w_rlast = (r_rd_state == R_DATA) && (r_cnt == r_rlen);

  // Read FSM: accept one AR, then stream LEN+1 zero beats with DECERR.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_rd_state <= R_IDLE;
      r_rid      <= '0;
      r_rlen     <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (s.ARVALID) begin
            r_rid      <= s.ARID;
            r_rlen     <= s.ARLEN;
            r_cnt      <= '0;
            r_rd_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (s.RREADY) begin
            // The last beat returns to idle without stepping cnt, so a
            // 16-beat burst never wraps the LW-bit counter.
            if (w_rlast) r_rd_state <= R_IDLE;
            else         r_cnt      <= r_cnt + LW'(1);
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  // Write FSM: accept AW, sink W beats until WLAST, then hold B until taken.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_wr_state <= W_IDLE;
      r_bid      <= '0;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          if (s.AWVALID) begin
            r_bid      <= s.AWID;
            r_wr_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (s.WVALID && s.WLAST) r_wr_state <= W_RESP;
        end
        W_RESP: begin
          if (s.BREADY) r_wr_state <= W_IDLE;
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  assign s.ARREADY = (r_rd_state == R_IDLE);
  assign s.RVALID  = (r_rd_state == R_DATA);
  assign s.RLAST   = w_rlast;
  assign s.RID     = r_rid;
  assign s.RDATA   = {DW{1'b0}};
  assign s.RRESP   = RESP_DECERR;

  assign s.AWREADY = (r_wr_state == W_IDLE);
  assign s.WREADY  = (r_wr_state == W_DATA);
  assign s.BVALID  = (r_wr_state == W_RESP);
  assign s.BID     = r_bid;
  assign s.BRESP   = RESP_DECERR;

endmodule
